// File: rtl/sdram_if_pkg.sv
// Shared types and constants for the SDRAM write path: FSM state encoding and word geometry.
package sdram_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_ACK,
    ST_DONE
  } sdram_wr_state_t;

  localparam int WORD_BYTES = 16;
  localparam int ADDR_STEP  = 16;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Small synchronous FIFO buffering result words between the MAC and the Avalon write master.
module sdram_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 128
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, wr_d;
  logic [PW:0]  rd_q, rd_d;
  logic         push_ok;
  logic         pop_ok;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[PW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign wr_d    = wr_q + (PW+1)'(push_ok);
  assign rd_d    = rd_q + (PW+1)'(pop_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/sdram_writer.sv
// Avalon write master storing 128-bit result words to consecutive 16-byte SDRAM addresses.
// Optional ack timeout with sticky error: define SDRAM_WRITER_TIMEOUT_EN.
module sdram_writer
  import sdram_if_pkg::*;
#(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int INTERFACE_ADDR_BITS  = 26,
  parameter int FIFO_DEPTH           = 8,
  parameter int COUNT_BITS           = 16,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                              interface_clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [INTERFACE_ADDR_BITS-1:0]    base_address,
  input  logic [COUNT_BITS-1:0]             words_total,
  input  logic [INTERFACE_WIDTH_BITS-1:0]   in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
  output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
  output logic                              interface_write,
  output logic                              interface_read,
  output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
  input  logic                              interface_acknowledge,
  output logic                              busy,
  output logic                              done,
  output logic [COUNT_BITS-1:0]             words_written,
  output logic                              error
);

  localparam int AW = INTERFACE_ADDR_BITS;
  localparam int W  = INTERFACE_WIDTH_BITS;

  sdram_wr_state_t           state_q;
  logic [AW-1:0]             addr_q;
  logic [COUNT_BITS-1:0]     remaining_q;
  logic [COUNT_BITS-1:0]     words_written_q;
  logic [W-1:0]              wdata_q;
  logic                      write_q;
  logic                      done_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic [W-1:0]              fifo_head;

`ifdef SDRAM_WRITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q;
  logic             error_q;
`endif

  assign fifo_pop = (state_q == ST_LOAD) && (remaining_q != '0) && !fifo_empty;

  sdram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (W)
  ) u_fifo (
    .clk_i   (interface_clock),
    .rst_i   (reset),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // NOTE: every register here uses <= so all updates in a cycle see the same pre-edge values.
  always_ff @(posedge interface_clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      words_written_q <= '0;
      wdata_q         <= '0;
      write_q         <= 1'b0;
      done_q          <= 1'b0;
`ifdef SDRAM_WRITER_TIMEOUT_EN
      timer_q         <= '0;
      error_q         <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q          <= base_address & ~AW'(WORD_BYTES - 1);
            remaining_q     <= words_total;
            words_written_q <= '0;
            state_q         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (remaining_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (!fifo_empty) begin
            wdata_q <= fifo_head;
            write_q <= 1'b1;
            state_q <= ST_WRITE;
`ifdef SDRAM_WRITER_TIMEOUT_EN
            timer_q <= '0;
`endif
          end
        end
        ST_WRITE: begin
          if (interface_acknowledge) begin
            write_q <= 1'b0;
            state_q <= ST_ACK;
          end
`ifdef SDRAM_WRITER_TIMEOUT_EN
          else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up on this word: it is not counted as written.
            write_q <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        ST_ACK: begin
          addr_q          <= addr_q + AW'(ADDR_STEP);
          remaining_q     <= remaining_q - 1'b1;
          words_written_q <= words_written_q + 1'b1;
          if (remaining_q == COUNT_BITS'(1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready              = !fifo_full;
  assign interface_address     = addr_q;
  assign interface_byte_enable = '1;
  assign interface_write       = write_q;
  assign interface_read        = 1'b0;
  assign interface_write_data  = wdata_q;
  assign busy                  = (state_q != ST_IDLE);
  assign done                  = done_q;
  assign words_written         = words_written_q;

`ifdef SDRAM_WRITER_TIMEOUT_EN
  assign error = error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign error              = 1'b0;
`endif

endmodule
